// File: rtl/bitvert_col_sched.sv
// bitvert_col_sched: per-column control sequencer for a bit-serial
// activation MAC. A job latches the activations and their sum, then steps
// through PRIME, CLR, PRE, eight COL cycles (bit 7 down to 0), FLUSH and DONE,
// replaying one stored config word per bit column.
// Optional build macro SCHED_INTERNAL_SUM_EN: sum_act is computed here from
// act_in; otherwise it is latched from the sum_act_in port.
module bitvert_col_sched #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LENGTH = 8,
  localparam int unsigned SEL_W  = $clog2(VEC_LENGTH) + 1,
  localparam int unsigned SUM_W  = $clog2(VEC_LENGTH) + DATA_WIDTH,
  localparam int unsigned N_SEL  = VEC_LENGTH / 2,
  localparam int unsigned ASEL_W = N_SEL * SEL_W,
  localparam int unsigned CFG_W  = ASEL_W + SEL_W + 6,
  localparam int unsigned ACT_W  = VEC_LENGTH * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [CFG_W-1:0]        cfg_wdata,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [ACT_W-1:0]        act_in,
`ifndef SCHED_INTERNAL_SUM_EN
  input  logic signed [SUM_W-1:0] sum_act_in,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    mac_en,
  output logic                    mac_rst,
  output logic [ACT_W-1:0]        act_out,
  output logic [ASEL_W-1:0]       act_sel,
  output logic [SEL_W-1:0]        hamming_sel,
  output logic                    hamming_sign,
  output logic signed [SUM_W-1:0] sum_act,
  output logic [2:0]              column_idx,
  output logic [2:0]              mul_const,
  output logic                    is_shift_mul,
  output logic                    is_msb,
  output logic                    is_skip_zero
);

  localparam int unsigned N_COL   = 8;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned HSEL_LO = 6;
  localparam int unsigned ASEL_LO = HSEL_LO + SEL_W;
  localparam logic [SEL_W-1:0]  SEL_ZERO  = SEL_W'(VEC_LENGTH);
  localparam logic [ASEL_W-1:0] ASEL_ZERO = {N_SEL{SEL_ZERO}};
  localparam logic [COL_W-1:0]  COL_TOP   = COL_W'(N_COL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_CLR, S_PRE, S_COL, S_FLUSH, S_DONE
  } state_t;

  state_t r_state, w_state_n;
  logic [COL_W-1:0] r_col, w_col_n, w_prev_idx;
  logic [CFG_W-1:0] r_cfg [N_COL];
  logic [CFG_W-1:0] w_cur, w_prev;
  logic             w_accept;

  logic [ACT_W-1:0]        r_act;
  logic signed [SUM_W-1:0] r_sum, w_sum;

  logic              r_start_ready, r_busy, r_done, r_mac_en, r_mac_rst;
  logic [ASEL_W-1:0] r_act_sel;
  logic [SEL_W-1:0]  r_hsel;
  logic              r_hsign, r_shift, r_msb, r_skip;
  logic [2:0]        r_mul, r_col_idx;

  logic              w_start_ready, w_busy, w_done, w_mac_en, w_mac_rst;
  logic [ASEL_W-1:0] w_act_sel;
  logic [SEL_W-1:0]  w_hsel;
  logic              w_hsign, w_shift, w_msb, w_skip;
  logic [2:0]        w_mul, w_col_idx;

`ifdef SCHED_INTERNAL_SUM_EN
  // Sign-extended sum of all activations at full SUM_W width.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
      w_sum = w_sum + SUM_W'($signed(act_in[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end
`else
  assign w_sum = sum_act_in;
`endif

  // Next state, column counter and next registered control values.
  always_comb begin
    w_state_n     = r_state;
    w_col_n       = r_col;
    w_accept      = 1'b0;
    w_start_ready = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_mac_en      = 1'b0;
    w_mac_rst     = 1'b0;
    w_act_sel     = ASEL_ZERO;
    w_hsel        = SEL_ZERO;
    w_hsign       = 1'b0;
    w_mul         = 3'd0;
    w_shift       = 1'b0;
    w_msb         = 1'b0;
    w_skip        = 1'b1;
    w_col_idx     = 3'd0;
    w_prev_idx    = '0;
    w_cur         = '0;
    w_prev        = '0;

    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_accept  = 1'b1;
          w_state_n = S_PRIME;
        end
      end
      S_PRIME: w_state_n = S_CLR;
      S_CLR:   w_state_n = S_PRE;
      S_PRE: begin
        w_state_n = S_COL;
        w_col_n   = COL_TOP;
      end
      S_COL: begin
        if (r_col == '0) begin
          w_state_n = S_FLUSH;
          w_col_n   = COL_TOP;
        end else begin
          w_col_n = r_col - 3'd1;
        end
      end
      S_FLUSH: w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (w_state_n)
      S_IDLE:  w_start_ready = 1'b1;
      S_PRIME: begin
        w_busy   = 1'b1;
        w_mac_en = 1'b1;
      end
      S_CLR: begin
        w_busy    = 1'b1;
        w_mac_rst = 1'b1;
      end
      S_PRE: begin
        w_busy    = 1'b1;
        w_act_sel = r_cfg[COL_TOP][ASEL_LO +: ASEL_W];
      end
      S_COL: begin
        w_busy     = 1'b1;
        w_mac_en   = 1'b1;
        w_prev_idx = w_col_n - 3'd1;
        w_cur      = r_cfg[w_col_n];
        w_prev     = r_cfg[w_prev_idx];
        w_col_idx  = w_col_n;
        w_msb      = (w_col_n == COL_TOP);
        w_hsel     = w_cur[HSEL_LO +: SEL_W];
        w_hsign    = w_cur[5];
        w_mul      = w_cur[4:2];
        w_shift    = w_cur[1];
        w_skip     = w_cur[0];
        // act_sel runs one column ahead of the rest of the controls.
        w_act_sel  = (w_col_n == '0) ? ASEL_ZERO : w_prev[ASEL_LO +: ASEL_W];
      end
      S_FLUSH: begin
        w_busy   = 1'b1;
        w_mac_en = 1'b1;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: w_start_ready = 1'b1;
    endcase
  end

  // State, counter and control output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_col         <= COL_TOP;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mac_en      <= 1'b0;
      r_mac_rst     <= 1'b0;
      r_act_sel     <= ASEL_ZERO;
      r_hsel        <= SEL_ZERO;
      r_hsign       <= 1'b0;
      r_mul         <= 3'd0;
      r_shift       <= 1'b0;
      r_msb         <= 1'b0;
      r_skip        <= 1'b1;
      r_col_idx     <= 3'd0;
    end else begin
      r_state       <= w_state_n;
      r_col         <= w_col_n;
      r_start_ready <= w_start_ready;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_mac_en      <= w_mac_en;
      r_mac_rst     <= w_mac_rst;
      r_act_sel     <= w_act_sel;
      r_hsel        <= w_hsel;
      r_hsign       <= w_hsign;
      r_mul         <= w_mul;
      r_shift       <= w_shift;
      r_msb         <= w_msb;
      r_skip        <= w_skip;
      r_col_idx     <= w_col_idx;
    end
  end

  // Column config buffer; writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_COL; i++) r_cfg[i] <= '0;
    end else if (cfg_we && (r_state == S_IDLE)) begin
      r_cfg[cfg_addr] <= cfg_wdata;
    end
  end

  // Job operands, held from acceptance until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act <= '0;
      r_sum <= '0;
    end else if (w_accept) begin
      r_act <= act_in;
      r_sum <= w_sum;
    end
  end

  assign start_ready  = r_start_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign mac_en       = r_mac_en;
  assign mac_rst      = r_mac_rst;
  assign act_out      = r_act;
  assign sum_act      = r_sum;
  assign act_sel      = r_act_sel;
  assign hamming_sel  = r_hsel;
  assign hamming_sign = r_hsign;
  assign mul_const    = r_mul;
  assign is_shift_mul = r_shift;
  assign is_msb       = r_msb;
  assign is_skip_zero = r_skip;
  assign column_idx   = r_col_idx;

endmodule

// File: doc/bitvert_col_sched.md
BITVERT_COL_SCHED -- requirements
Module: bitvert_col_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 8, activation width.
REQ-002 Parameter VEC_LENGTH, default 8, activations per vector; derived SEL_W = clog2(VEC_LENGTH)+1 = 4 and SUM_W = clog2(VEC_LENGTH)+DATA_WIDTH = 11.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  column-config write strobe.
- cfg_addr  in  3  column index to write.
- cfg_wdata  in  26  column config word, fields given in REQ-007.
- start_valid  in  1  job request.
- start_ready  out  1  scheduler can accept a job.
- act_in  in  VEC_LENGTH x DATA_WIDTH signed  job activations.
- sum_act_in  in  SUM_W signed  external activation sum; present only without SCHED_INTERNAL_SUM_EN.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- mac_en  out  1  MAC accumulate enable.
- mac_rst  out  1  MAC synchronous clear.
- act_out  out  VEC_LENGTH x DATA_WIDTH  latched activations.
- act_sel  out  VEC_LENGTH/2 x SEL_W  activation mux selects.
- hamming_sel  out  SEL_W  Hamming operand select.
- hamming_sign  out  1  Hamming operand negate.
- sum_act  out  SUM_W signed  activation sum.
- column_idx  out  3  current bit column.
- mul_const  out  3  sum_act multiplier constant.
- is_shift_mul  out  1  shift the multiplier result by 3.
- is_msb  out  1  current column is the sign column.
- is_skip_zero  out  1  zero bits are skipped in this column.

Function
REQ-004 FSM states SHALL be IDLE, PRIME, CLR, PRE, COL, FLUSH and DONE; all outputs are registered.
REQ-005 IDLE: start_ready=1, busy=0. start_valid&&start_ready latches act_in into act_out and latches sum_act, then moves to PRIME.
REQ-006 Sequence SHALL be PRIME(1) -> CLR(1) -> PRE(1) -> COL(8, column counter 7 down to 0) -> FLUSH(1) -> DONE(1) -> IDLE; start to done = 13 cycles.
REQ-007 Config word fields SHALL be: [25:22] act_sel[3], [21:18] act_sel[2], [17:14] act_sel[1], [13:10] act_sel[0], [9:6] hamming_sel, [5] hamming_sign, [4:2] mul_const, [1] is_shift_mul, [0] is_skip_zero. Storage is an 8-entry buffer indexed by column.
REQ-008 The ZERO control set SHALL be: every act_sel=8, hamming_sel=8 (select index 8 is the zero operand), hamming_sign=0, mul_const=0, is_shift_mul=0, is_skip_zero=1, is_msb=0, column_idx=0.
REQ-009 PRIME: mac_en=1, mac_rst=0, ZERO controls, so the MAC pipeline registers are flushed to zero.
REQ-010 CLR: mac_rst=1, mac_en=0, ZERO controls.
REQ-011 PRE: mac_en=0; act_sel = cfg[7].act_sel; all other controls ZERO.
REQ-012 act_sel SHALL lead the other controls by one cycle. In COL with counter c: mac_en=1, column_idx=c, is_msb=(c==7), non-act_sel fields from cfg[c], act_sel from cfg[c-1]; act_sel=8 when c==0.
REQ-013 FLUSH: mac_en=1, ZERO controls.
REQ-014 DONE: done=1 for one cycle, busy=0 from the next cycle; the MAC result is final at the start of DONE.
REQ-015 busy=1 in every state from PRIME through FLUSH; start_ready=0 in every state except IDLE.
REQ-016 cfg_we is honoured only in IDLE and ignored otherwise. A write in the same cycle as an accepted start SHALL update the buffer before PRIME.
REQ-017 act_out and sum_act SHALL stay stable from acceptance until the next accepted start.
REQ-018 start_valid asserted outside IDLE is not accepted and is not queued.

Reset
REQ-019 Asynchronous reset SHALL force: FSM to IDLE, column counter to 7, config buffer to zero, act_out=0, sum_act=0, mac_en=0, mac_rst=0, done=0, busy=0, start_ready=1, ZERO controls.
REQ-020 Reset mid-job SHALL abort the job with no done pulse; the next job after reset behaves as the first.

Configuration
REQ-021 Macro SCHED_INTERNAL_SUM_EN defined: sum_act is the signed sum of act_in computed at acceptance at full SUM_W width, and port sum_act_in is absent.
REQ-022 Macro SCHED_INTERNAL_SUM_EN undefined: sum_act latches sum_act_in at acceptance and no adder tree is built.

Verification
REQ-023 Write cfg[7] = act_sel {1,2,3,4} with is_skip_zero=1; start -> PRE cycle shows act_sel={1,2,3,4}; first COL cycle shows column_idx=7, is_msb=1, is_skip_zero=1.
REQ-024 Start at cycle 0 -> mac_en pattern 1,0,0,1,1,1,1,1,1,1,1,1,0 over cycles 1..13; mac_rst=1 only at cycle 2; done=1 only at cycle 13.
REQ-025 Raise start_valid during COL -> start_ready=0 and the job is not accepted; the job completes normally.
REQ-026 Assert reset during COL with c=4 -> all outputs take their reset values immediately; no done pulse.
REQ-027 With SCHED_INTERNAL_SUM_EN, act_in all -128 -> sum_act=-1024; act_in {127,-1,0,5,3,-8,2,1} -> sum_act=129.
REQ-028 cfg_we with cfg_addr=3 during busy -> cfg[3] unchanged in the next job.
